// File: rtl/cpu_pkg.sv
// Shared 6502 core definitions.
// Provides default bus widths, the fetch address used after reset, and the
// hardware vector locations (NMI, RESET, IRQ/BRK) that redirects target.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_DATA_W = 8;

  localparam logic [15:0] CPU_RESET_PC = 16'h0000;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/prefetch_fifo.sv
// Byte storage for the prefetch queue: DEPTH entries, circular read/write
// pointers and an occupancy count.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : synchronous empty (pointers and count to zero)
//   wr_en/wr_data: append one byte at the tail
//   rd_en        : drop the head entry (caller only asserts when non-empty)
//   rd_data      : head entry
//   count        : occupied entries, 0..DEPTH
module prefetch_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (!wr_en && rd_en) count <= count - CW'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch unit for the 6502 core.
// Streams sequential byte reads from a fixed-latency memory port into a
// DEPTH-entry queue, tagging the head byte with its address.
//   clk, reset_n         : clock, asynchronous active-low reset
//   rdy                  : 6502 RDY; low stalls issue of new reads only
//   flush, flush_addr    : redirect; drops queue and in-flight reads
//   mem_req/mem_addr     : read request and its address
//   mem_rdata            : read data, MEM_LATENCY edges after the request
//   q_valid/q_data/q_pc  : head entry, its byte and its address
//   q_pop                : consume the head entry
//   q_count              : occupied entries
//   fetch_pc             : next address to be requested
module prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned        ADDR_W      = CPU_ADDR_W,
  parameter int unsigned        DATA_W      = CPU_DATA_W,
  parameter int unsigned        DEPTH       = 4,
  parameter int unsigned        MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0]  RESET_PC    = ADDR_W'(CPU_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_addr,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       q_valid,
  output logic [DATA_W-1:0]          q_data,
  output logic [ADDR_W-1:0]          q_pc,
  input  logic                       q_pop,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic [ADDR_W-1:0]          fetch_pc
);

  localparam int unsigned IW = $clog2(DEPTH + MEM_LATENCY + 1);

  // Bit i set: a read issued i+1 edges ago is still outstanding.
  logic [MEM_LATENCY-1:0] lat_sr;
  logic [IW-1:0]          inflight;
  logic [IW-1:0]          occupancy;
  logic                   push;
  logic                   pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < MEM_LATENCY; i++)
      inflight = inflight + IW'(lat_sr[i]);
  end

  // Credit check counts reads already in flight, so a response always
  // finds a free slot.
  assign occupancy = IW'(q_count) + inflight;
  assign mem_req   = reset_n & rdy & ~flush & (occupancy < IW'(DEPTH));
  assign mem_addr  = fetch_pc;

  assign push    = lat_sr[MEM_LATENCY-1] & ~flush;
  assign q_valid = (q_count != '0);
  assign pop     = q_pop & q_valid & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_sr   <= '0;
      fetch_pc <= RESET_PC;
      q_pc     <= RESET_PC;
    end else if (flush) begin
      lat_sr   <= '0;
      fetch_pc <= flush_addr;
      q_pc     <= flush_addr;
    end else begin
      lat_sr <= (lat_sr << 1) | MEM_LATENCY'(mem_req);
      if (mem_req) fetch_pc <= fetch_pc + ADDR_W'(1);
      if (pop)     q_pc     <= q_pc + ADDR_W'(1);
    end
  end

  prefetch_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .wr_en   (push),
    .wr_data (mem_rdata),
    .rd_en   (pop),
    .rd_data (q_data),
    .count   (q_count)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed scenarios followed by a
// randomized run, all compared each cycle against a transaction-level model
// (queue of fetched addresses plus a list of outstanding reads with their
// issue cycle).
module tb_prefetch_queue;
  import cpu_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int L  = 2;
  localparam int CW = $clog2(D+1);

  logic          clk;
  logic          reset_n;
  logic          rdy;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          q_valid;
  logic [DW-1:0] q_data;
  logic [AW-1:0] q_pc;
  logic          q_pop;
  logic [CW-1:0] q_count;
  logic [AW-1:0] fetch_pc;

  prefetch_queue #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH       (D),
    .MEM_LATENCY (L),
    .RESET_PC    (16'h0000)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rdy        (rdy),
    .flush      (flush),
    .flush_addr (flush_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .q_valid    (q_valid),
    .q_data     (q_data),
    .q_pc       (q_pc),
    .q_pop      (q_pop),
    .q_count    (q_count),
    .fetch_pc   (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dfn(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Memory: the address seen at an edge is answered L edges later.
  logic [AW-1:0] apipe [L];
  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
  end
  assign mem_rdata = dfn(apipe[L-1]);

  typedef struct {
    logic [AW-1:0] a;
    int            c;
  } req_t;

  logic [AW-1:0] mq [$];
  req_t          infl [$];
  logic [AW-1:0] m_fpc;
  logic [AW-1:0] m_qpc;
  int            cyc_n;
  int            checks;
  int            errors;
  int            n_req;
  logic          s_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic [AW-1:0] fa, input logic p);
    logic exp_req;
    logic had;
    rdy = r; flush = f; flush_addr = fa; q_pop = p;
    @(negedge clk);
    exp_req = reset_n && r && !f && ((mq.size() + infl.size()) < D);
    chk("mem_req", mem_req, exp_req);
    if (exp_req) chk("mem_addr", mem_addr, m_fpc);
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("q_pc", q_pc, m_qpc);
    chk("q_valid", q_valid, mq.size() != 0);
    chk("q_count", q_count, mq.size());
    if (mq.size() != 0) chk("q_data", q_data, dfn(mq[0]));
    s_valid = q_valid;
    n_req += int'(mem_req);
    if (reset_n) begin
      if (f) begin
        mq.delete(); infl.delete();
        m_fpc = fa; m_qpc = fa;
      end else begin
        had = (mq.size() != 0);
        if (infl.size() != 0 && infl[0].c + L == cyc_n) begin
          mq.push_back(infl[0].a);
          infl.pop_front();
        end
        if (p && had) begin
          mq.pop_front();
          m_qpc++;
        end
        if (exp_req) begin
          infl.push_back('{m_fpc, cyc_n});
          m_fpc++;
        end
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    mq.delete(); infl.delete();
    m_fpc = '0; m_qpc = '0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_q_valid", q_valid, 1'b0);
    chk("rst_q_count", q_count, 0);
    chk("rst_fetch_pc", fetch_pc, 16'h0000);
    chk("rst_q_pc", q_pc, 16'h0000);
    chk("rst_q_data", q_data, 8'h00);
    repeat (n) cyc(1'b1, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    int streak;
    logic [AW-1:0] fpc_hold;
    checks = 0; errors = 0; cyc_n = 0; n_req = 0;
    rdy = 0; flush = 0; flush_addr = '0; q_pop = 0; reset_n = 0;
    #2;
    do_reset(2);

    // Fill without popping: exactly DEPTH requests, then stall.
    n_req = 0;
    repeat (8) cyc(1'b1, 1'b0, '0, 1'b0);
    chk("fill_req_count", n_req, D);
    chk("fill_q_count", q_count, D);
    chk("fill_q_data", q_data, 8'h00);
    chk("fill_q_pc", q_pc, 16'h0000);

    // Continuous pop from reset: no bubbles after the L+1 cycle fill.
    do_reset(1);
    streak = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b1, 1'b0, '0, 1'b1);
      if (i >= 3 && i <= 22 && s_valid) streak++;
    end
    chk("stream_no_gaps", streak, 20);

    // Address wrap while streaming.
    cyc(1'b1, 1'b1, VEC_IRQ, 1'b1);
    repeat (10) cyc(1'b1, 1'b0, '0, 1'b1);
    chk("wrap_fetch_pc", fetch_pc < 16'h0010, 1'b1);

    // Flush with reads in flight and entries queued; coincident pop ignored.
    cyc(1'b1, 1'b1, 16'h1000, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 16'hC000, 1'b1);
    chk("flush_q_count", q_count, 0);
    chk("flush_q_valid", q_valid, 1'b0);
    chk("flush_q_pc", q_pc, 16'hC000);
    repeat (6) cyc(1'b1, 1'b0, '0, 1'b0);
    chk("flush_first_data", q_data, 8'hC0);
    chk("flush_first_pc", q_pc, 16'hC000);

    // RDY stall with pops continuing.
    repeat (6) cyc(1'b1, 1'b0, '0, 1'b1);
    fpc_hold = m_fpc;
    n_req = 0;
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("stall_no_req", n_req, 0);
    chk("stall_drained", q_count, 0);
    chk("stall_fetch_hold", fetch_pc, fpc_hold);
    repeat (4) cyc(1'b1, 1'b0, '0, 1'b1);

    // Pop on empty queue changes nothing; flush accepted while stalled.
    cyc(1'b0, 1'b1, VEC_RESET, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("empty_pop_q_pc", q_pc, VEC_RESET);
    chk("empty_pop_count", q_count, 0);
    repeat (3) cyc(1'b1, 1'b0, '0, 1'b0);

    // Randomized traffic with occasional mid-stream reset.
    for (int i = 0; i < 2000; i++) begin
      logic [AW-1:0] fa;
      fa = ($urandom_range(0, 3) == 0) ? (VEC_NMI + AW'($urandom_range(0, 5)))
                                       : AW'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset(1);
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, fa,
          $urandom_range(0, 9) < 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
